// File: rtl/if_fetch.sv
// Instruction-fetch stage. Walks a 32-bit PC through a variable-latency
// instruction memory and hands each returned word, with its PC+4, to the IF/ID
// pipeline register. A one-entry buffer keeps a word that arrives while the
// hazard unit is stalling. Redirects from later stages flush IF/ID and restart
// fetch at the new target. A redirect that lands while an access is still
// outstanding lets that access finish, then throws its data away.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        reloj,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] PC_4,
  output logic [31:0] DO,
  output logic        enableIF,
  output logic        resetIF
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDiscard
  } state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  // Address of the access being drained in StDiscard. pc already holds the
  // redirect target at that point.
  logic [31:0] discard_addr;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  // The adder wraps at 2^32, so a fetch at 32'hFFFF_FFFC yields PC+4 = 0.
  assign pc_plus4            = pc + 32'd4;
  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch FSM and PC/buffer state. Redirect outranks both stall and ack.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      pc           <= {RESET_PC[31:2], 2'b00};
      buf_instr    <= 32'h0;
      buf_pc4      <= 32'h0;
      discard_addr <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (redirect) begin
            pc <= redirect_tgt;
          end
          state <= StReq;
        end
        StReq: begin
          if (redirect) begin
            pc <= redirect_tgt;
            if (!imem_ack) begin
              // Access still in flight. Memory must see it finish at the old address.
              discard_addr <= pc;
              state        <= StDiscard;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (stall) begin
              buf_instr <= imem_data;
              buf_pc4   <= pc_plus4;
              state     <= StHold;
            end
          end
        end
        StHold: begin
          if (redirect) begin
            pc    <= redirect_tgt;
            state <= StReq;
          end else if (!stall) begin
            state <= StReq;
          end
        end
        StDiscard: begin
          if (redirect) begin
            pc <= redirect_tgt;
          end
          // Once the old access completes, drop its data and start fetching at pc.
          if (imem_ack) begin
            state <= StReq;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs are combinational. A word must reach IF/ID in the cycle it is acked,
  // and reset has to show on the outputs before the next clock edge.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    enableIF  = 1'b0;
    resetIF   = 1'b0;
    DO        = buf_instr;
    PC_4      = buf_pc4;
    if (!reset_n) begin
      resetIF = 1'b1;
      DO      = 32'h0;
      PC_4    = 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          resetIF = 1'b1;
        end
        StReq: begin
          imem_req = 1'b1;
          if (redirect) begin
            resetIF = 1'b1;
          end else if (imem_ack && !stall) begin
            enableIF = 1'b1;
            DO       = imem_data;
            PC_4     = pc_plus4;
          end
        end
        StHold: begin
          if (redirect) begin
            resetIF = 1'b1;
          end else if (!stall) begin
            enableIF = 1'b1;
          end
        end
        StDiscard: begin
          imem_req  = 1'b1;
          imem_addr = discard_addr;
          if (redirect) begin
            resetIF = 1'b1;
          end
        end
        default: begin
          resetIF = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 reloj  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  input  1  SHALL be the hazard-unit hold: the pipeline register must not be written this cycle.
REQ-005 redirect  input  1  SHALL be the taken-branch/jump pulse from a later stage.
REQ-006 redirect_pc  input  32  SHALL be the redirect target; bits [1:0] ignored and treated as 00.
REQ-007 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-008 imem_addr  output  32  SHALL be the instruction-memory word address, byte-addressed.
REQ-009 imem_ack  input  1  SHALL be the memory completion strobe, variable latency of 0..N cycles after imem_req.
REQ-010 imem_data  input  32  SHALL be the instruction word, valid only when imem_ack=1.
REQ-011 PC_4  output  32  SHALL be the fetched instruction's address + 4, toward the IF/ID register.
REQ-012 DO  output  32  SHALL be the fetched instruction word, toward the IF/ID register.
REQ-013 enableIF  output  1  SHALL be the IF/ID write enable.
REQ-014 resetIF  output  1  SHALL be the IF/ID flush, active-high.

Function
REQ-015 Block SHALL implement states IDLE, REQ, HOLD and DISCARD, plus a 32-bit pc, buf_instr and buf_pc4.
REQ-016 IDLE SHALL drive imem_req=0 and resetIF=1, and SHALL go to REQ next cycle; if redirect=1, pc<=redirect_pc.
REQ-017 REQ SHALL drive imem_req=1 and imem_addr=pc, with the address held stable until imem_ack.
REQ-018 REQ with imem_ack=1, redirect=0, stall=0 SHALL drive enableIF=1, DO=imem_data and PC_4=pc+4 in the same cycle, then set pc<=pc+4 and stay in REQ.
REQ-019 REQ with imem_ack=1, redirect=0, stall=1 SHALL drive enableIF=0, then set buf_instr<=imem_data, buf_pc4<=pc+4 and pc<=pc+4, and go to HOLD.
REQ-020 HOLD SHALL drive imem_req=0 and DO=buf_instr, PC_4=buf_pc4; when stall=0, it SHALL drive enableIF=1 and go to REQ.
REQ-021 Redirect SHALL take priority over stall and ack; in any state it SHALL drive resetIF=1, force enableIF=0 and set pc<=redirect_pc.
REQ-022 Redirect in REQ without imem_ack SHALL go to DISCARD; redirect in REQ with imem_ack, or in HOLD, SHALL drop the data and go to REQ.
REQ-023 DISCARD SHALL keep imem_req=1 at the old address until imem_ack, discard that data, and then go to REQ at the new pc.
REQ-024 Redirect in DISCARD SHALL update pc and remain in DISCARD.
REQ-025 When enableIF=0, DO and PC_4 SHALL show buf_instr and buf_pc4.
REQ-026 enableIF and resetIF SHALL never be 1 in the same cycle, and no instruction SHALL be delivered twice or skipped.
REQ-027 pc+4 SHALL be modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 imem_ack outside REQ/DISCARD SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, buf_instr=0, buf_pc4=0, imem_req=0, enableIF=0, resetIF=1, DO=0, PC_4=0.
REQ-030 Reset asserted mid-request SHALL abandon the access, and the first imem_ack after reset release SHALL be ignored unless it follows a new imem_req.

Verification
REQ-031 Release reset, 0-wait ack, no stall -> imem_addr 0,4,8; enableIF=1 each cycle; PC_4 = 4, 8, 12.
REQ-032 Ack for addr 8 arrives while stall=1 for 3 cycles -> enableIF=0 for 3 cycles; DO held at the addr-8 word; then one enableIF pulse with PC_4=12, and the next imem_addr is 12.
REQ-033 Redirect to 32'h0000_0100 while addr 0x10 is pending with 2-cycle latency -> resetIF pulse; addr 0x10 stays stable until ack; that data is discarded; the next imem_addr is 0x100.
REQ-034 Redirect with stall=1 in HOLD -> resetIF=1, enableIF=0, the buffer is dropped, and the next fetch is at redirect_pc.
REQ-035 RESET_PC=32'hFFFF_FFFC -> the first delivery has PC_4=0, and the second fetch address is 0.
REQ-036 Assert reset_n=0 for 1 cycle with imem_req pending -> all outputs are at reset values that same cycle, with no enableIF for the stale ack.
